// File: rtl/iob_fifo2stream_pkg.sv
// Shared helpers for the FIFO-to-stream read-side consumer.
// Latency: none, combinational helpers only.
// Backpressure: not applicable.
package iob_fifo2stream_pkg;

    // Words buffered plus the word still returning from the FIFO (0..2).
    function automatic logic [1:0] occ_of(input logic [1:0] count, input logic inflight);
        return count + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/iob_fifo2stream_buf.sv
// Two-entry register FIFO that absorbs the one-cycle FIFO read latency.
// Latency: a write is visible at rd_data on the next cycle; rd_data is the head, combinational.
// Backpressure: none internally; the caller never writes when full without reading in the same cycle.
module iob_fifo2stream_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cke,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count
);

    localparam int DEPTH = 2;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // Storage, pointers and fill count; a clear empties the buffer and zeroes the head word.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (cke) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= wr_data;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (rd_en) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_q + {1'b0, wr_en} - {1'b0, rd_en};
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // The issue rule upstream must never overfill or underflow the buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
        (cke && !rst) |-> !(wr_en && !rd_en && count_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (!arst_n)
        (cke && !rst) |-> !(rd_en && count_q == 2'd0));

endmodule

// File: rtl/iob_fifo2stream.sv
// Drives the FIFO read port and presents words as a valid/ready stream with optional frame-end marking.
// Latency: first word valid two cycles after the read strobe; sustains one word per cycle.
// Backpressure: reads stop as soon as buffered plus in-flight words reach two and the sink is not popping.
module iob_fifo2stream
    import iob_fifo2stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              fifo_r_en_o,
    input  logic [DATA_W-1:0] fifo_r_data_i,
    input  logic              fifo_empty_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic [1:0]        level_o
);

    logic             inflight_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic [1:0]       count;
    logic [1:0]       occ;
    logic             pop;
    logic             issue;

    iob_fifo2stream_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk_i),
        .arst_n  (arst_n_i),
        .cke     (cke_i),
        .rst     (rst_i),
        .wr_en   (inflight_q),
        .wr_data (fifo_r_data_i),
        .rd_en   (pop),
        .rd_data (data_o),
        .count   (count)
    );

    assign valid_o = (count != 2'd0);
    // A clear wins over a pop in the same cycle.
    assign pop     = valid_o & ready_i & cke_i & ~rst_i;
    assign occ     = occ_of(count, inflight_q);

    // ready_i reaches the read strobe combinationally so a full buffer can refill while it drains.
    assign issue = arst_n_i & cke_i & ~rst_i & en_i & ~fifo_empty_i &
                   ((occ < 2'd2) | ((occ == 2'd2) & pop));

    assign fifo_r_en_o = issue;
    assign level_o     = occ;

    // The frame length is sampled on its first word; later len_i changes wait for the next frame.
    assign len_eff = (word_cnt_q == '0) ? len_i : len_q;
    assign last_o  = valid_o & (len_eff != '0) & (word_cnt_q == len_eff - 1'b1);

    // Track the read whose data arrives on the next cycle; a clear drops it.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            inflight_q <= 1'b0;
        end else if (cke_i) begin
            inflight_q <= rst_i ? 1'b0 : issue;
        end
    end

    // Frame word counter and latched frame length, advanced on each accepted word.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            word_cnt_q <= '0;
            len_q      <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                word_cnt_q <= '0;
                len_q      <= '0;
            end else if (pop) begin
                if (word_cnt_q == '0) len_q <= len_i;
                word_cnt_q <= last_o ? '0 : word_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo2stream.sv
// Bench for iob_fifo2stream: FIFO source model, reference scoreboard, vector table and corner sequences.
// Latency: not applicable.
// Backpressure: ready_i driven from tables and randomly.
module tb_iob_fifo2stream;

    logic        clk_i = 1'b0;
    logic        arst_n_i, cke_i, rst_i, en_i;
    logic [15:0] len_i;
    logic        fifo_r_en_o;
    logic [31:0] fifo_r_data_i;
    logic        fifo_empty_i;
    logic        valid_o, ready_i, last_o;
    logic [31:0] data_o;
    logic [1:0]  level_o;

    always #5 clk_i = ~clk_i;

    iob_fifo2stream #(.DATA_W(32), .LEN_W(16)) dut (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .cke_i         (cke_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .len_i         (len_i),
        .fifo_r_en_o   (fifo_r_en_o),
        .fifo_r_data_i (fifo_r_data_i),
        .fifo_empty_i  (fifo_empty_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .last_o        (last_o),
        .level_o       (level_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] src[$];
    logic [31:0] exp_q[$];
    int          m_pos = 0;
    logic [15:0] m_len = '0;
    int          n_acc = 0;
    int          n_rd  = 0;
    logic [31:0] last_mask = '0;

    typedef struct {
        logic        en;
        logic        ready;
        logic        exp_ren;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic [1:0]  exp_level;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] w);
        src.push_back(w);
        exp_q.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    task automatic to_neg();
        @(negedge clk_i);
    endtask

    // Call at the negative edge: scores any accepted word, then advances one clock and serves the read.
    task automatic adv();
        logic        rd, acc, el;
        logic [15:0] l;
        rd  = fifo_r_en_o;
        acc = valid_o & ready_i & cke_i & ~rst_i & arst_n_i;
        if (rst_i || !arst_n_i) m_pos = 0;
        if (acc) begin
            if (n_acc < 32) last_mask[n_acc[4:0]] = last_o;
            n_acc++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra: got word %h, expected none", data_o);
            end else begin
                chk("sb_data", data_o, exp_q.pop_front());
            end
            l = (m_pos == 0) ? len_i : m_len;
            if (m_pos == 0) m_len = len_i;
            el = (l != 0) && (m_pos == int'(l) - 1);
            chk("sb_last", last_o, el);
            m_pos = el ? 0 : (m_pos + 1) % 65536;
        end
        if (rd) n_rd++;
        @(posedge clk_i);
        #1;
        if (rd) begin
            if (src.size() > 0) begin
                fifo_r_data_i = src.pop_front();
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL read_empty: read strobe while FIFO empty");
            end
        end
        fifo_empty_i = (src.size() == 0);
    endtask

    task automatic sync_clear();
        rst_i = 1'b1;
        to_neg();
        chk("clr_no_issue", fifo_r_en_o, 0);
        adv();
        rst_i = 1'b0;
        src.delete();
        exp_q.delete();
        fifo_empty_i = 1'b1;
        n_acc = 0;
        n_rd = 0;
        last_mask = '0;
        m_pos = 0;
    endtask

    task automatic frame_run(input string name, input int n, input logic [15:0] la,
                             input int sw, input logic [15:0] lb, input logic [31:0] mask);
        sync_clear();
        len_i = la;
        en_i = 1'b1;
        ready_i = 1'b1;
        for (int k = 0; k < n; k++) push(32'h100 + k);
        for (int c = 0; c < n + 20 && n_acc < n; c++) begin
            to_neg();
            adv();
            if (sw > 0 && n_acc >= sw) len_i = lb;
        end
        chk({name, "_cnt"}, n_acc, n);
        chk({name, "_mask"}, last_mask, mask);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        int          pushed;

        arst_n_i = 1'b1; cke_i = 1'b1; rst_i = 1'b0; en_i = 1'b1; ready_i = 1'b0;
        len_i = 16'd3; fifo_empty_i = 1'b1; fifo_r_data_i = '0;

        //           en  rdy  ren val data          last lvl
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 2'd1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 2'd2};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 2'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 2'd2};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 2'd1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 2'd1};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0};

        // Asynchronous reset with a non-empty FIFO: every output held at zero.
        #2 arst_n_i = 1'b0;
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        to_neg();
        chk("rst_ren", fifo_r_en_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_data", data_o, 0);
        adv();
        arst_n_i = 1'b1;

        // Release followed by the table: issue, fill, stall, stream, drain with en_i low.
        for (int i = 0; i < 10; i++) begin
            en_i = tbl[i].en;
            ready_i = tbl[i].ready;
            to_neg();
            chk($sformatf("tbl%0d_ren", i), fifo_r_en_o, tbl[i].exp_ren);
            chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_level", i), level_o, tbl[i].exp_level);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
                chk($sformatf("tbl%0d_last", i), last_o, tbl[i].exp_last);
            end
            adv();
        end

        // Back-to-back streaming of eight words with no bubbles.
        sync_clear();
        len_i = 16'd0; en_i = 1'b1; ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) push(k);
        for (int c = 0; c < 12; c++) begin
            to_neg();
            chk("stream_ren", fifo_r_en_o, (c < 8));
            chk("stream_valid", valid_o, (c >= 2 && c < 10));
            if (c >= 2 && c < 10) chk("stream_data", data_o, c - 1);
            adv();
        end

        // Frame marking.
        frame_run("frame_len3", 7, 16'd3, 0, 16'd3, 32'h24);
        frame_run("frame_switch", 7, 16'd3, 2, 16'd2, 32'h54);
        frame_run("frame_len0", 7, 16'd0, 0, 16'd0, 32'h00);
        frame_run("frame_len1", 7, 16'd1, 0, 16'd1, 32'h7F);

        // Fill to two, hold under cke_i=0, drain with en_i=0, then run the FIFO empty.
        sync_clear();
        len_i = 16'd0; en_i = 1'b1; ready_i = 1'b0;
        for (int k = 0; k < 5; k++) push(32'hC0 + k);
        for (int c = 0; c < 4; c++) begin to_neg(); adv(); end
        to_neg();
        chk("fill_level", level_o, 2);
        chk("fill_ren", fifo_r_en_o, 0);
        adv();
        cke_i = 1'b0; ready_i = 1'b1;
        to_neg();
        chk("cke_ren", fifo_r_en_o, 0);
        adv();
        cke_i = 1'b1; ready_i = 1'b0;
        to_neg();
        chk("cke_hold_level", level_o, 2);
        chk("cke_hold_data", data_o, 32'hC0);
        adv();
        en_i = 1'b0; ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            to_neg();
            chk("dis_ren", fifo_r_en_o, 0);
            adv();
        end
        to_neg();
        chk("dis_level", level_o, 0);
        chk("dis_valid", valid_o, 0);
        adv();
        en_i = 1'b1;
        for (int c = 0; c < 10; c++) begin to_neg(); adv(); end
        to_neg();
        chk("empty_ren", fifo_r_en_o, 0);
        chk("empty_level", level_o, 0);
        chk("empty_words", n_acc, 5);
        adv();

        // Synchronous clear mid-stream with two words outstanding.
        sync_clear();
        len_i = 16'd3; en_i = 1'b1; ready_i = 1'b1;
        for (int k = 0; k < 10; k++) push(32'hD0 + k);
        for (int c = 0; c < 3; c++) begin to_neg(); adv(); end
        to_neg();
        chk("pre_rst_level", level_o, 2);
        adv();
        rst_i = 1'b1;
        to_neg();
        chk("rst_pulse_ren", fifo_r_en_o, 0);
        adv();
        rst_i = 1'b0;
        src.delete();
        exp_q.delete();
        n_acc = 0; n_rd = 0; last_mask = '0;
        for (int k = 0; k < 6; k++) push(32'hA0 + k);
        to_neg();
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_level", level_o, 0);
        adv();
        for (int c = 0; c < 20 && n_acc < 3; c++) begin to_neg(); adv(); end
        chk("post_rst_frame", last_mask & 32'h7, 32'h4);

        // Random backpressure, enable and length changes against the scoreboard.
        sync_clear();
        pushed = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
            ready_i = ($urandom_range(0, 99) < 60);
            en_i = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 99) < 3) len_i = 16'($urandom_range(0, 4));
            if (pushed < 1000 && src.size() < 6 && $urandom_range(0, 1) == 1) begin
                push($urandom);
                pushed++;
            end
            to_neg();
            chk("bp_level", level_o, n_rd - n_acc);
            if (fifo_r_en_o)
                chk("bp_issue_gate",
                    en_i & ~fifo_empty_i & ((n_rd - n_acc < 2) | (valid_o & ready_i)), 1);
            if (prev_stall) begin
                chk("bp_hold_valid", valid_o, 1);
                chk("bp_hold_data", data_o, prev_data);
            end
            prev_stall = valid_o & ~ready_i;
            prev_data = data_o;
            adv();
        end
        chk("bp_word_count", n_acc, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
